// File: rtl/config_loader_pkg.sv
// Shared definitions for the configuration-chain loader.
//   state_t    : loader FSM states
//   CRC8_POLY  : CRC-8 generator polynomial (x^8 + x^2 + x + 1)
//   CRC8_INIT  : CRC-8 seed value
//   crc8_step  : one bit-serial CRC-8 update, MSB-first, no reflection
package config_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'hFF;

  function automatic logic [7:0] crc8_step(input logic [7:0] crc_in, input logic bit_in);
    logic fb;
    fb = crc_in[7] ^ bit_in;
    return {crc_in[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 register.
//   clk    : clock
//   rst_n  : asynchronous active-low reset (loads CRC8_INIT)
//   init   : synchronous re-seed to CRC8_INIT (priority over en)
//   en     : absorb bit_in this cycle
//   bit_in : serial data bit
//   crc    : current CRC value
module crc8_serial
  import config_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init,
  input  logic       en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC8_INIT;
    end else if (init) begin
      crc <= CRC8_INIT;
    end else if (en) begin
      crc <= crc8_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/config_loader.sv
// Bitstream loader for the daisy-chained configuration shift registers.
// Accepts words over valid/ready, shifts them MSB-first into the chain head,
// then optionally recirculates the chain once from its tail and compares a
// CRC-8 of the recirculated stream with the CRC taken during load.
//   config_clk  : clock shared with the chain
//   sys_reset   : asynchronous active-low reset
//   start/abort : one-cycle control pulses (abort wins)
//   word_in/word_valid/word_ready : bitstream word handshake
//   chain_tail  : serial output of the last chain element
//   config_en/config_data : chain shift enable and head data
//   busy/done/error : LOAD-or-VERIFY / DONE / ERR status
//   bit_count   : bits shifted in the current phase
//   crc         : load-phase CRC
module config_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1),
  parameter bit          VERIFY_EN = 1'b1
) (
  input  logic              config_clk,
  input  logic              sys_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              chain_tail,
  output logic              config_en,
  output logic              config_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  bit_count,
  output logic [7:0]        crc
);

  localparam int unsigned BC_W = $clog2(WORD_W + 1);

  state_t            state, next_state;
  logic [WORD_W-1:0] shift_buf;
  logic [BC_W-1:0]   buf_cnt;
  logic [7:0]        crc_l, crc_v;
  logic              start_ok, accept, last_bit;
  int unsigned       loaded, take;

  always_comb begin
    // loaded counts bits already shifted plus bits still waiting in the buffer
    loaded     = 32'(bit_count) + 32'(buf_cnt);
    take       = (loaded < CHAIN_LEN) ? (CHAIN_LEN - loaded) : 0;
    if (take > WORD_W) take = WORD_W;
    start_ok   = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    word_ready = (state == ST_LOAD) && (buf_cnt <= BC_W'(1)) && (loaded < CHAIN_LEN);
    accept     = word_valid && word_ready;
    config_en  = 1'b0;
    config_data = 1'b0;
    if (state == ST_LOAD && buf_cnt != '0) begin
      config_en   = 1'b1;
      config_data = shift_buf[WORD_W-1];
    end else if (state == ST_VERIFY) begin
      config_en   = 1'b1;
      config_data = chain_tail;
    end
    last_bit = config_en && (32'(bit_count) == CHAIN_LEN - 1);
    busy     = (state == ST_LOAD) || (state == ST_VERIFY);
    done     = (state == ST_DONE);
    error    = (state == ST_ERR);
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: if (start) next_state = ST_LOAD;
      ST_LOAD: begin
        if (abort)         next_state = ST_IDLE;
        else if (last_bit) next_state = VERIFY_EN ? ST_VERIFY : ST_DONE;
      end
      ST_VERIFY: begin
        if (abort)         next_state = ST_IDLE;
        else if (last_bit) next_state = (crc8_step(crc_v, chain_tail) == crc_l) ? ST_DONE : ST_ERR;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge config_clk or negedge sys_reset) begin
    if (!sys_reset) state <= ST_IDLE;
    else            state <= next_state;
  end

  always_ff @(posedge config_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      shift_buf <= '0;
      buf_cnt   <= '0;
      bit_count <= '0;
    end else if (start_ok) begin
      buf_cnt   <= '0;
      bit_count <= '0;
    end else if (busy && abort) begin
      buf_cnt   <= '0;
    end else if (state == ST_LOAD) begin
      // an accept at buf_cnt == 1 replaces the buffer while its last bit shifts out
      if (accept) begin
        shift_buf <= word_in;
        buf_cnt   <= BC_W'(take);
      end else if (buf_cnt != '0) begin
        shift_buf <= shift_buf << 1;
        buf_cnt   <= buf_cnt - BC_W'(1);
      end
      if (config_en) begin
        bit_count <= (last_bit && VERIFY_EN) ? '0 : bit_count + CNT_W'(1);
      end
    end else if (state == ST_VERIFY) begin
      bit_count <= bit_count + CNT_W'(1);
    end
  end

  crc8_serial u_crc_load (
    .clk    (config_clk),
    .rst_n  (sys_reset),
    .init   (start_ok),
    .en     (state == ST_LOAD && config_en),
    .bit_in (config_data),
    .crc    (crc_l)
  );

  crc8_serial u_crc_verify (
    .clk    (config_clk),
    .rst_n  (sys_reset),
    .init   (start_ok),
    .en     (state == ST_VERIFY),
    .bit_in (chain_tail),
    .crc    (crc_v)
  );

  assign crc = crc_l;

endmodule
